// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and registers the returned word into the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect outranks stall so a taken branch is never lost behind a hazard.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    count_d    = count_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      misalign_d = |redirect_pc[1:0];
    end else if (!stall) begin
      instr_d  = imem_rdata;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      valid_d  = 1'b1;
      pc_d     = pc_plus4;
      count_d  = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= {RESET_PC[31:2], 2'b00};
      instr_q    <= NOP_INSTR;
      id_pc_q    <= 32'd0;
      id_pc4_q   <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr      = {2'b00, pc_q[31:2]};
  assign if_id_instr    = instr_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_pc4_q;
  assign if_id_valid    = valid_q;
  assign misalign_err   = misalign_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory word k holds 32'hA000_0000 + k.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'hA000_0000 + imem_addr;

  fetch_stage #(
    .RESET_PC (32'h0000_0100),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s got=%08h exp=%08h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    step(); step();
    check("rst_instr", if_id_instr, 32'h0000_0013);
    check("rst_pc", if_id_pc, 32'h0);
    check("rst_pc4", if_id_pc_plus4, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_mis", {31'd0, misalign_err}, 32'd0);
    check("rst_cnt", fetch_count, 32'd0);
    check("rst_addr", imem_addr, 32'h40);

    // Sequential fetch from RESET_PC
    rst = 1'b0;
    step();
    check("f1_pc", if_id_pc, 32'h100);
    check("f1_instr", if_id_instr, 32'hA000_0040);
    check("f1_valid", {31'd0, if_id_valid}, 32'd1);
    step(); step();
    check("f3_pc", if_id_pc, 32'h108);
    check("f3_instr", if_id_instr, 32'hA000_0042);
    check("f3_pc4", if_id_pc_plus4, 32'h10C);
    check("f3_cnt", fetch_count, 32'd3);

    // Stall holds everything for 4 cycles
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stl_pc", if_id_pc, 32'h108);
      check("stl_cnt", fetch_count, 32'd3);
      check("stl_addr", imem_addr, 32'h43);
    end
    stall = 1'b0;
    step();
    check("rel_pc", if_id_pc, 32'h10C);
    check("rel_instr", if_id_instr, 32'hA000_0043);
    check("rel_cnt", fetch_count, 32'd4);

    // Redirect while stalled: redirect wins, one bubble
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    check("rd_valid", {31'd0, if_id_valid}, 32'd0);
    check("rd_instr", if_id_instr, 32'h0000_0013);
    check("rd_addr", imem_addr, 32'h80);
    check("rd_idpc", if_id_pc, 32'h10C);
    check("rd_cnt", fetch_count, 32'd4);
    check("rd_mis", {31'd0, misalign_err}, 32'd0);
    stall = 1'b0; redirect_valid = 1'b0;
    step();
    check("rd2_pc", if_id_pc, 32'h200);
    check("rd2_valid", {31'd0, if_id_valid}, 32'd1);
    check("rd2_instr", if_id_instr, 32'hA000_0080);
    check("rd2_cnt", fetch_count, 32'd5);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    check("mis_flag", {31'd0, misalign_err}, 32'd1);
    check("mis_addr", imem_addr, 32'h80);
    redirect_valid = 1'b0;
    step();
    check("mis_clr", {31'd0, misalign_err}, 32'd0);
    check("mis_pc", if_id_pc, 32'h200);
    check("mis_cnt", fetch_count, 32'd6);

    // PC wrap at top of address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    check("wr_cnt", fetch_count, 32'd6);
    redirect_valid = 1'b0;
    step();
    check("wr1_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wr1_pc4", if_id_pc_plus4, 32'h0);
    check("wr1_instr", if_id_instr, 32'hDFFF_FFFF);
    step();
    check("wr2_pc", if_id_pc, 32'h0);
    check("wr2_pc4", if_id_pc_plus4, 32'h4);
    check("wr2_instr", if_id_instr, 32'hA000_0000);
    check("wr2_cnt", fetch_count, 32'd8);

    // Back-to-back redirects
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h400;
    step();
    check("bb_valid", {31'd0, if_id_valid}, 32'd0);
    check("bb_addr", imem_addr, 32'h100);
    redirect_valid = 1'b0;
    step();
    check("bb_pc", if_id_pc, 32'h400);
    check("bb_instr", if_id_instr, 32'hA000_0100);

    // Reset beats redirect and stall
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h503; stall = 1'b1;
    step();
    check("mr_instr", if_id_instr, 32'h0000_0013);
    check("mr_pc", if_id_pc, 32'h0);
    check("mr_pc4", if_id_pc_plus4, 32'h0);
    check("mr_valid", {31'd0, if_id_valid}, 32'd0);
    check("mr_mis", {31'd0, misalign_err}, 32'd0);
    check("mr_cnt", fetch_count, 32'd0);
    check("mr_addr", imem_addr, 32'h40);
    rst = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    step();
    check("mr2_pc", if_id_pc, 32'h100);
    check("mr2_cnt", fetch_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
